// File: rtl/gol_ctrl.sv
// rtl/gol_ctrl.sv - Game-of-Life core sequencer: load, run, step and stop detection
module gol_ctrl #(
  parameter int GEN_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd,
  input  logic [63:0]      i_seed,
  input  logic [GEN_W-1:0] i_gen_limit,
  output logic             o_load,
  output logic [63:0]      o_seed,
  output logic             o_step,
  input  logic [63:0]      i_board,
  output logic             o_busy,
  output logic             o_done,
  output logic [1:0]       o_reason,
  output logic [GEN_W-1:0] o_gen
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_CHECK,
    S_DONE
  } state_e;

  localparam logic [1:0] CMD_LOAD = 2'd0;
  localparam logic [1:0] CMD_RUN  = 2'd1;
  localparam logic [1:0] CMD_STEP = 2'd2;
  localparam logic [1:0] CMD_STOP = 2'd3;

  localparam logic [1:0] RSN_LIMIT   = 2'd0;
  localparam logic [1:0] RSN_EXTINCT = 2'd1;
  localparam logic [1:0] RSN_STABLE  = 2'd2;
  localparam logic [1:0] RSN_USER    = 2'd3;

  state_e           state_q, state_d;
  logic [63:0]      seed_q, seed_d;
  logic [63:0]      prev_q, prev_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic [GEN_W-1:0] limit_q, limit_d;
  logic [1:0]       reason_q, reason_d;
  logic             done_q, done_d;
  logic             run_q, run_d;
  logic             stop_q, stop_d;

  logic             cmd_acc;
  logic             stop_now;
  logic             stop_hit;
  logic [1:0]       stop_rsn;
  logic [GEN_W-1:0] gen_inc;

  assign o_cmd_ready = (state_q != S_LOAD);
  assign o_load      = (state_q == S_LOAD);
  assign o_step      = (state_q == S_ISSUE);
  assign o_busy      = (state_q == S_LOAD) || (state_q == S_ISSUE) || (state_q == S_CHECK);
  assign o_done      = done_q;
  assign o_seed      = seed_q;
  assign o_reason    = reason_q;
  assign o_gen       = gen_q;

  assign cmd_acc  = i_cmd_valid && o_cmd_ready;
  assign gen_inc  = (&gen_q) ? gen_q : gen_q + GEN_W'(1);
  // A STOP arriving during CHECK itself counts for this CHECK.
  assign stop_now = stop_q || (cmd_acc && (i_cmd == CMD_STOP));

  always_comb begin
    stop_hit = 1'b1;
    stop_rsn = RSN_USER;
    if (i_board == 64'd0) begin
      stop_rsn = RSN_EXTINCT;
    end else if (i_board == prev_q) begin
      stop_rsn = RSN_STABLE;
    end else if ((limit_q != '0) && (gen_inc >= limit_q)) begin
      stop_rsn = RSN_LIMIT;
    end else begin
      stop_hit = stop_now;
    end
  end

  always_comb begin
    state_d  = state_q;
    seed_d   = seed_q;
    prev_d   = prev_q;
    gen_d    = gen_q;
    limit_d  = limit_q;
    reason_d = reason_q;
    done_d   = 1'b0;
    run_d    = run_q;
    stop_d   = stop_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (cmd_acc) begin
          case (i_cmd)
            CMD_LOAD: begin
              seed_d   = i_seed;
              reason_d = RSN_LIMIT;
              state_d  = S_LOAD;
            end
            CMD_RUN: begin
              limit_d  = i_gen_limit;
              run_d    = 1'b1;
              reason_d = RSN_LIMIT;
              state_d  = S_ISSUE;
            end
            CMD_STEP: begin
              run_d    = 1'b0;
              reason_d = RSN_LIMIT;
              state_d  = S_ISSUE;
            end
            default: ;
          endcase
        end
      end
      S_LOAD: begin
        gen_d   = '0;
        prev_d  = 64'd0;
        state_d = S_IDLE;
      end
      S_ISSUE: begin
        prev_d  = i_board;
        state_d = S_CHECK;
        if (cmd_acc && (i_cmd == CMD_STOP)) begin
          stop_d = 1'b1;
        end
      end
      S_CHECK: begin
        gen_d   = gen_inc;
        state_d = S_ISSUE;
        if (stop_now) begin
          stop_d = 1'b1;
        end
        // Step mode always ends here; without a real condition it reports USER.
        if (stop_hit || !run_q) begin
          state_d  = S_DONE;
          reason_d = stop_rsn;
          done_d   = 1'b1;
          stop_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_IDLE;
      seed_q   <= 64'd0;
      prev_q   <= 64'd0;
      gen_q    <= '0;
      limit_q  <= '0;
      reason_q <= RSN_LIMIT;
      done_q   <= 1'b0;
      run_q    <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      seed_q   <= seed_d;
      prev_q   <= prev_d;
      gen_q    <= gen_d;
      limit_q  <= limit_d;
      reason_q <= reason_d;
      done_q   <= done_d;
      run_q    <= run_d;
      stop_q   <= stop_d;
    end
  end

endmodule

// File: tb/tb_gol_ctrl.sv
// tb/tb_gol_ctrl.sv - vector-table bench for gol_ctrl with a behavioural life core
module tb_gol_ctrl;

  localparam logic [1:0] C_LOAD = 2'd0, C_RUN = 2'd1, C_STEP = 2'd2, C_STOP = 2'd3;
  localparam logic [1:0] R_LIMIT = 2'd0, R_EXT = 2'd1, R_STABLE = 2'd2, R_USER = 2'd3;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic [1:0]  i_cmd = 2'd0;
  logic [63:0] i_seed = 64'd0;
  logic [15:0] i_gen_limit = 16'd0;
  logic        o_load;
  logic [63:0] o_seed;
  logic        o_step;
  logic [63:0] i_board = 64'd0;
  logic        o_busy;
  logic        o_done;
  logic [1:0]  o_reason;
  logic [15:0] o_gen;

  gol_ctrl #(.GEN_W(16)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_cmd_valid(i_cmd_valid),
    .o_cmd_ready(o_cmd_ready), .i_cmd(i_cmd), .i_seed(i_seed),
    .i_gen_limit(i_gen_limit), .o_load(o_load), .o_seed(o_seed),
    .o_step(o_step), .i_board(i_board), .o_busy(o_busy), .o_done(o_done),
    .o_reason(o_reason), .o_gen(o_gen)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [63:0] life(input logic [63:0] b);
    logic [63:0] nb;
    nb = 64'd0;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        int n;
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            if (dx != 0 || dy != 0) begin
              n += int'(b[((x + dx + 8) % 8) + 8 * ((y + dy + 8) % 8)]);
            end
          end
        end
        nb[x + 8 * y] = (n == 3) || (b[x + 8 * y] && n == 2);
      end
    end
    return nb;
  endfunction

  always @(posedge i_clk) begin
    if (o_load) i_board <= o_seed;
    else if (o_step) i_board <= life(i_board);
  end

  int n_cmp = 0;
  int n_bad = 0;
  int overlap = 0;

  always @(negedge i_clk) if (o_load && o_step) overlap++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] c, input logic [63:0] s, input logic [15:0] l);
    @(negedge i_clk);
    i_cmd_valid = 1'b1; i_cmd = c; i_seed = s; i_gen_limit = l;
    for (int k = 0; k < 50 && !o_cmd_ready; k++) @(negedge i_clk);
    @(posedge i_clk);
    #1 i_cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int steps, output int gap_err, output logic seen);
    int last;
    steps = 0; gap_err = 0; seen = 1'b0; last = -1;
    for (int c = 0; c < 400; c++) begin
      @(negedge i_clk);
      if (o_step) begin
        if (last >= 0 && (c - last) != 2) gap_err++;
        last = c;
        steps++;
      end
      if (o_done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_load(input logic [63:0] s);
    send(C_LOAD, s, 16'd0);
    @(negedge i_clk);
    chk("load_pulse", {63'd0, o_load}, 64'd1);
    @(negedge i_clk);
    chk("load_gen", {48'd0, o_gen}, 64'd0);
    chk("load_seed", o_seed, s);
  endtask

  typedef struct {
    logic        ld;
    logic [63:0] seed;
    logic [1:0]  cmd;
    logic [15:0] limit;
    logic [1:0]  rsn;
    logic [15:0] gen;
    int          steps;
    logic [63:0] board;
  } vec_t;

  vec_t vecs[7];

  logic [63:0] blinker_v, blinker_h, block2, cell00, glider;
  int          steps, gaps;
  logic        seen;

  initial begin
    blinker_v = (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35);
    blinker_h = (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28);
    block2    = (64'd1 << 9) | (64'd1 << 10) | (64'd1 << 17) | (64'd1 << 18);
    cell00    = 64'd1;
    glider    = (64'd1 << 1) | (64'd1 << 10) | (64'd1 << 16) | (64'd1 << 17) | (64'd1 << 18);

    vecs[0] = '{1'b1, blinker_v, C_RUN,  16'd4,  R_LIMIT,  16'd4,  4,  blinker_v};
    vecs[1] = '{1'b1, block2,    C_RUN,  16'd0,  R_STABLE, 16'd1,  1,  block2};
    vecs[2] = '{1'b1, cell00,    C_STEP, 16'd0,  R_EXT,    16'd1,  1,  64'd0};
    vecs[3] = '{1'b0, 64'd0,     C_STEP, 16'd0,  R_EXT,    16'd2,  1,  64'd0};
    vecs[4] = '{1'b1, glider,    C_RUN,  16'd32, R_LIMIT,  16'd32, 32, glider};
    vecs[5] = '{1'b1, blinker_v, C_STEP, 16'd0,  R_USER,   16'd1,  1,  blinker_h};
    vecs[6] = '{1'b1, blinker_v, C_RUN,  16'd3,  R_LIMIT,  16'd3,  3,  blinker_h};

    #2;
    chk("rst_ready", {63'd0, o_cmd_ready}, 64'd1);
    chk("rst_busy", {63'd0, o_busy}, 64'd0);
    chk("rst_gen", {48'd0, o_gen}, 64'd0);
    chk("rst_seed", o_seed, 64'd0);
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].ld) do_load(vecs[v].seed);
      send(vecs[v].cmd, 64'd0, vecs[v].limit);
      wait_done(steps, gaps, seen);
      chk($sformatf("v%0d_done", v), {63'd0, seen}, 64'd1);
      chk($sformatf("v%0d_reason", v), {62'd0, o_reason}, {62'd0, vecs[v].rsn});
      chk($sformatf("v%0d_gen", v), {48'd0, o_gen}, {48'd0, vecs[v].gen});
      chk($sformatf("v%0d_steps", v), 64'(steps), 64'(vecs[v].steps));
      chk($sformatf("v%0d_gap", v), 64'(gaps), 64'd0);
      chk($sformatf("v%0d_board", v), i_board, vecs[v].board);
      @(negedge i_clk);
      chk($sformatf("v%0d_done_pulse", v), {63'd0, o_done}, 64'd0);
    end

    // STEP during ISSUE is dropped; STOP accepted in ISSUE of cycle 7 ends at the next CHECK
    do_load(glider);
    send(C_RUN, 64'd0, 16'd0);
    @(negedge i_clk);
    chk("b_issue1", {63'd0, o_step}, 64'd1);
    i_cmd_valid = 1'b1; i_cmd = C_STEP;
    @(posedge i_clk);
    #1 i_cmd_valid = 1'b0;
    for (int c = 2; c < 7; c++) @(negedge i_clk);
    @(negedge i_clk);
    chk("b_issue7", {63'd0, o_step}, 64'd1);
    i_cmd_valid = 1'b1; i_cmd = C_STOP;
    @(posedge i_clk);
    #1 i_cmd_valid = 1'b0;
    wait_done(steps, gaps, seen);
    chk("b_done", {63'd0, seen}, 64'd1);
    chk("b_reason", {62'd0, o_reason}, {62'd0, R_USER});
    chk("b_gen", {48'd0, o_gen}, 64'd4);
    chk("b_steps", 64'(steps), 64'd0);

    // STOP accepted in CHECK is honoured by that same CHECK
    do_load(glider);
    send(C_RUN, 64'd0, 16'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    chk("c_check", {63'd0, o_busy && !o_step}, 64'd1);
    i_cmd_valid = 1'b1; i_cmd = C_STOP;
    @(posedge i_clk);
    #1 i_cmd_valid = 1'b0;
    wait_done(steps, gaps, seen);
    chk("c_done", {63'd0, seen}, 64'd1);
    chk("c_reason", {62'd0, o_reason}, {62'd0, R_USER});
    chk("c_gen", {48'd0, o_gen}, 64'd1);
    chk("c_steps", 64'(steps), 64'd0);

    // STOP in DONE does nothing and the reason is held
    send(C_STOP, 64'd0, 16'd0);
    @(negedge i_clk);
    chk("d_busy", {63'd0, o_busy}, 64'd0);
    chk("d_reason", {62'd0, o_reason}, {62'd0, R_USER});

    // Asynchronous reset in the middle of a run
    do_load(blinker_v);
    send(C_RUN, 64'd0, 16'd0);
    for (int c = 1; c < 5; c++) @(negedge i_clk);
    @(negedge i_clk);
    chk("e_in_issue", {63'd0, o_step}, 64'd1);
    i_reset_n = 1'b0;
    #1;
    chk("e_step", {63'd0, o_step}, 64'd0);
    chk("e_busy", {63'd0, o_busy}, 64'd0);
    chk("e_gen", {48'd0, o_gen}, 64'd0);
    chk("e_reason", {62'd0, o_reason}, 64'd0);
    chk("e_seed", o_seed, 64'd0);
    chk("e_done", {63'd0, o_done}, 64'd0);
    chk("e_ready", {63'd0, o_cmd_ready}, 64'd1);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      if (o_done || o_busy) seen = 1'b1;
    end
    chk("e_quiet", {63'd0, seen}, 64'd0);
    do_load(block2);
    send(C_RUN, 64'd0, 16'd0);
    wait_done(steps, gaps, seen);
    chk("e2_done", {63'd0, seen}, 64'd1);
    chk("e2_reason", {62'd0, o_reason}, {62'd0, R_STABLE});
    chk("e2_gen", {48'd0, o_gen}, 64'd1);

    chk("load_step_overlap", 64'(overlap), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gol_ctrl.md
GOL_CTRL -- requirements
Module: gol_ctrl

Interface
REQ-001 Parameter GEN_W, default 16, width of the generation counter and limit.
REQ-002 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 i_reset_n  in  1  asynchronous, active-low reset.
REQ-004 i_cmd_valid  in  1  command offered.
REQ-005 o_cmd_ready  out  1  command accepted when i_cmd_valid && o_cmd_ready at rising edge.
REQ-006 i_cmd  in  2  0=LOAD, 1=RUN, 2=STEP, 3=STOP.
REQ-007 i_seed  in  64  board for LOAD, sampled on acceptance; bit x+8y is cell (x,y).
REQ-008 i_gen_limit  in  GEN_W  RUN generation limit, sampled on RUN acceptance; 0 = unlimited.
REQ-009 o_load  out  1  one-cycle pulse; core replaces its board with o_seed.
REQ-010 o_seed  out  64  seed register driven to core.
REQ-011 o_step  out  1  one-cycle pulse; core computes one generation with toroidal wrap.
REQ-012 i_board  in  64  core board; valid on the cycle after o_load or o_step.
REQ-013 o_busy  out  1  high in LOAD, ISSUE, CHECK.
REQ-014 o_done  out  1  one-cycle pulse on entry to DONE.
REQ-015 o_reason  out  2  0=LIMIT, 1=EXTINCT, 2=STABLE, 3=USER; held until next LOAD/RUN/STEP acceptance.
REQ-016 o_gen  out  GEN_W  generations completed since last LOAD.

Function
REQ-017 States IDLE, LOAD, ISSUE, CHECK, DONE; o_cmd_ready = 1 in IDLE, DONE, ISSUE, CHECK; 0 in LOAD.
REQ-018 IDLE/DONE: LOAD -> capture i_seed into o_seed, go LOAD; RUN -> capture limit, mode=run, go ISSUE; STEP -> mode=step, go ISSUE; STOP -> no effect, stay.
REQ-019 LOAD: o_load=1 one cycle, o_gen cleared to 0, prev-board register cleared to 0, next state IDLE; no o_done.
REQ-020 ISSUE: o_step=1 one cycle, snapshot i_board into prev-board register, next state CHECK.
REQ-021 CHECK: o_gen increments by 1, saturating at all-ones; evaluate stop conditions on i_board vs prev-board.
REQ-022 Stop priority: i_board==0 -> EXTINCT; else i_board==prev -> STABLE; else limit!=0 and incremented o_gen>=limit -> LIMIT; else stop-request flag -> USER.
REQ-023 CHECK with stop condition -> DONE, o_done=1; step mode with no condition -> DONE, o_reason=USER; run mode with no condition -> ISSUE (one generation per 2 cycles).
REQ-024 STOP accepted in ISSUE/CHECK sets stop-request flag; honoured at the next CHECK (same-cycle acceptance in CHECK is honoured in that CHECK); flag cleared on DONE entry.
REQ-025 LOAD/RUN/STEP accepted in ISSUE/CHECK are dropped with no state change.
REQ-026 o_load and o_step never asserted in the same cycle; neither asserted outside LOAD/ISSUE respectively.
REQ-027 Saturated o_gen with limit all-ones stops LIMIT at all-ones; counter never wraps.
REQ-028 RUN or STEP with no prior LOAD operates on the core's current board.

Reset
REQ-029 Assertion of i_reset_n=0 immediately forces state IDLE, o_load=0, o_step=0, o_done=0, o_busy=0, o_seed=0, o_gen=0, o_reason=0, stop flag=0, prev-board=0, including mid-run.
REQ-030 o_cmd_ready=1 after reset; first rising edge after deassertion may accept a command.

Verification
REQ-031 LOAD seed with cells (3,2),(3,3),(3,4) (blinker), RUN limit 4 -> four o_step pulses 2 cycles apart, o_done with o_reason=LIMIT, o_gen=4, board equals seed.
REQ-032 LOAD 2x2 block at (1,1), RUN limit 0 -> o_done after 1 generation, o_reason=STABLE, o_gen=1.
REQ-033 LOAD single cell (0,0), STEP -> one o_step, o_done, o_reason=EXTINCT, o_gen=1; second STEP -> EXTINCT, o_gen=2.
REQ-034 LOAD glider, RUN limit 0, STOP issued in cycle 7 -> o_done at next CHECK, o_reason=USER; STEP in ISSUE dropped; glider wraps at edge (after 32 generations equals seed).
REQ-035 Drop i_reset_n mid-RUN between ISSUE and CHECK -> same cycle all outputs at reset values, no o_done; subsequent RUN restarts o_gen from 0 only after LOAD.
